// File: rtl/sdu_rx.sv
`default_nettype none
// ============================================================================
// sdu_rx : ADC capture buffer; records a ping into RAM, PC drains it per strobe.
// Revision: 1.0
// ============================================================================
module sdu_rx #(
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sdu_rx_en,
  input  logic              sdu_seq_done_strobe,
  input  logic [15:0]       sdu_rx_holdoff,
  input  logic [15:0]       adc_in,
  input  logic              sdu_rx_rd_strobe,
  input  logic              sdu_rx_clear,
  output logic [15:0]       sdu_rx_data,
  output logic              sdu_rx_valid,
  output logic              sdu_rx_ready,
  output logic [AWIDTH:0]   sdu_rx_count
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] c_depth    = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] c_last_idx = (AWIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLDOFF = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              en_d_q, en_d_d;
  logic [15:0]       hcnt_q, hcnt_d;
  logic [AWIDTH:0]   wr_idx_q, wr_idx_d;
  logic [AWIDTH:0]   rd_idx_q, rd_idx_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic [15:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              rd_pend_q, rd_pend_d;

  logic              ram_we;
  logic [AWIDTH-1:0] ram_addr;
  logic [15:0]       ram_rdata;
  logic [15:0]       mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    en_d_d    = sdu_rx_en;
    hcnt_d    = hcnt_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    count_d   = count_q;
    rd_pend_d = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = (state_q == S_CAPTURE) ? wr_idx_q[AWIDTH-1:0] : rd_idx_q[AWIDTH-1:0];
    // Second stage of the read pipe: RAM output lands in the data register.
    data_d    = rd_pend_q ? ram_rdata : data_q;
    valid_d   = rd_pend_q;

    case (state_q)
      S_IDLE: begin
        wr_idx_d = '0;
        rd_idx_d = '0;
        if (sdu_rx_en && !en_d_q) begin
          hcnt_d  = sdu_rx_holdoff;
          count_d = '0;
          state_d = (sdu_rx_holdoff != 16'd0) ? S_HOLDOFF : S_CAPTURE;
        end
      end
      S_HOLDOFF: begin
        if (!sdu_rx_en || sdu_seq_done_strobe) begin
          state_d = S_DONE;
          count_d = '0;
        end else if (hcnt_q == 16'd1) begin
          state_d = S_CAPTURE;
        end else begin
          hcnt_d = hcnt_q - 16'd1;
        end
      end
      S_CAPTURE: begin
        if (!sdu_rx_en) begin
          state_d = S_DONE;
        end else begin
          ram_we   = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
          if (count_q != c_depth) count_d = count_q + 1'b1;
          if (sdu_seq_done_strobe || (wr_idx_q == c_last_idx)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else if (sdu_rx_rd_strobe && (rd_idx_q < count_q)) begin
          rd_pend_d = 1'b1;
          rd_idx_d  = rd_idx_q + 1'b1;
        end else if ((rd_idx_q == count_q) && valid_q && !rd_pend_q) begin
          // Leave only once the final sample's valid pulse has been presented.
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (sdu_rx_clear) begin
      state_d   = S_IDLE;
      wr_idx_d  = '0;
      rd_idx_d  = '0;
      rd_pend_d = 1'b0;
      ram_we    = 1'b0;
      valid_d   = 1'b0;
      data_d    = data_q;
    end

    ready_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      en_d_q    <= 1'b0;
      hcnt_q    <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_d_q    <= en_d_d;
      hcnt_q    <= hcnt_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      count_q   <= count_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= adc_in;
    ram_rdata <= mem[ram_addr];
  end

  assign sdu_rx_data  = data_q;
  assign sdu_rx_valid = valid_q;
  assign sdu_rx_ready = ready_q;
  assign sdu_rx_count = count_q;

endmodule
`default_nettype wire

// File: doc/sdu_rx.md
# sdu_rx

Receive-side capture buffer for the SDUltrasound chain. It is the counterpart of the transmit replay buffer. During a ping it records raw ADC samples into an inferred single-port RAM at the fixed sample clock. Capture starts after a programmable holdoff and ends on sequence-done, on enable drop, or when the buffer is full. Once capture has ended, the PC drains the buffer one sample per read strobe. It sits between the ADC input path and the PC register/readback interface.

## Interface
- AWIDTH, 10, RAM address width; depth DEPTH = 2^AWIDTH samples
- clk  in  1  sample clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- sdu_rx_en  in  1  capture window enable; a rising edge arms capture
- sdu_seq_done_strobe  in  1  one-cycle pulse; ends capture
- sdu_rx_holdoff  in  16  samples to skip after the enable edge; latched at arm
- adc_in  in  16  raw ADC sample, valid every cycle
- sdu_rx_rd_strobe  in  1  PC read request, one sample per pulse
- sdu_rx_clear  in  1  one-cycle pulse; abandons the buffer and returns to IDLE
- sdu_rx_data  out  16  readback sample
- sdu_rx_valid  out  1  one-cycle pulse qualifying sdu_rx_data
- sdu_rx_ready  out  1  high while captured data is readable (DONE state)
- sdu_rx_count  out  AWIDTH+1  number of samples captured in the last capture

## Operation
- States: IDLE, HOLDOFF, CAPTURE, DONE.
- en_d is a registered copy of sdu_rx_en. The enable edge is sdu_rx_en=1 with en_d=0.
- IDLE:
  - wr_idx=0, rd_idx=0.
  - On an enable edge: latch holdoff into hcnt and clear count. Go to HOLDOFF if holdoff≠0, else CAPTURE.
  - A level-high enable without an edge does not arm.
- HOLDOFF:
  - hcnt decrements each cycle; go to CAPTURE when hcnt reaches 1.
  - Drop of sdu_rx_en or sdu_seq_done_strobe goes to DONE with count=0.
- CAPTURE:
  - Each cycle: RAM[wr_idx]←adc_in, wr_idx++, count++.
  - Exits to DONE after the write when any of these holds: sdu_seq_done_strobe=1, sdu_rx_en=0, or wr_idx=DEPTH-1 (full).
  - The sample present on the exit cycle is written, except when en=0: a cycle with en low writes nothing.
  - When several exit conditions hold in the same cycle, the result is identical: one transition.
- DONE:
  - sdu_rx_ready=1.
  - Each sdu_rx_rd_strobe with rd_idx<count reads RAM[rd_idx] and increments rd_idx.
  - A strobe with rd_idx≥count is ignored: no valid pulse.
  - After the read that makes rd_idx=count, return to IDLE on the cycle after its valid pulse.
  - count=0 returns to IDLE immediately.
  - sdu_rx_en and sdu_seq_done_strobe are ignored in DONE.
- sdu_rx_clear in any state goes to IDLE and zeroes the pointers. sdu_rx_count keeps its last value.
- The RAM address mux selects wr_idx in CAPTURE and rd_idx otherwise. No write is possible outside CAPTURE.
- Arithmetic: pointers are AWIDTH+1 bits unsigned. count saturates at DEPTH and never wraps.

## Timing
- Reset values: state=IDLE, sdu_rx_data=0, sdu_rx_valid=0, sdu_rx_ready=0, sdu_rx_count=0, en_d=0.
- Reset mid-capture or mid-readout discards everything. RAM contents are undefined afterwards.
- Let E0 be the edge at which the enable edge is detected. The first write captures the adc_in value present at edge E(1+H), where H is the latched holdoff.
- A done strobe at edge Ek writes the Ek sample, and the state is DONE after Ek. sdu_rx_ready rises one cycle after the last write.
- Read latency: a strobe at edge Ek produces sdu_rx_data/valid registered at edge E(k+1). Data holds until the next valid.
- Back-to-back strobes on every cycle are supported at full rate.
- A strobe arriving on the same cycle as sdu_rx_clear: clear wins and no valid pulse is produced.

## Test plan
- Basic capture: H=0, ramp adc_in=0,1,2…; en rises, done strobe at 8th CAPTURE cycle → count=8. Eight read strobes return 0..7, one valid each; then IDLE, ready=0.
- Holdoff: H=5, ramp adc_in; enable edge at sample value 100 → first stored sample is 106. A done strobe during HOLDOFF gives count=0 and ready only one cycle.
- Full buffer: AWIDTH=4, en held for 40 cycles → count=16, ready=1, exactly 16 samples stored. The 17th read strobe yields no valid.
- Re-arm rule: en held high through readout → no new capture. Drop en, raise en → new capture starts.
- Simultaneous: done strobe and en drop on the same cycle → single DONE transition, and that cycle's sample is not written. Clear plus rd_strobe together → no valid, state IDLE.
- Reset during CAPTURE at wr_idx=3 → all outputs at reset values next cycle. A following capture starts at address 0.
